// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer: accepts one signed input vector and runs N_LAYERS fully-connected layers back to back.
// Latency: load n_in beats, then n_out*(n_in+2) cycles per layer, then one output beat per cycle when ready.
// Backpressure: s_axis_tready is low while computing or streaming; m_axis stalls indefinitely with stable data.
// Optional macro SAT_CNT_EN adds sat_count, a saturating count of clipped neuron results for the current vector.
module mlp_layer_sequencer #(
  parameter int DATA_W   = 16,
  parameter int MAX_N    = 64,
  parameter int N_LAYERS = 4,
  parameter int SHIFT_W  = 5,
  localparam int LAYER_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1,
  localparam int NOUT_W  = $clog2(MAX_N + 1),
  localparam int ADDR_W  = (N_LAYERS * MAX_N * MAX_N > 1) ? $clog2(N_LAYERS * MAX_N * MAX_N) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_wr_en,
  input  logic [LAYER_W-1:0]        cfg_layer,
  input  logic [NOUT_W-1:0]         cfg_n_out,
  input  logic [SHIFT_W-1:0]        cfg_shift,
  input  logic                      cfg_relu,
  input  logic signed [DATA_W-1:0]  s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  output logic [ADDR_W-1:0]         w_raddr,
  input  logic signed [DATA_W-1:0]  w_rdata,
  output logic signed [DATA_W-1:0]  m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
`ifdef SAT_CNT_EN
  output logic [15:0]               sat_count,
`endif
  output logic                      busy,
  output logic                      err_len
);

  localparam int IDX_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int ACC_W = 2 * DATA_W + $clog2(MAX_N);
  localparam logic signed [DATA_W-1:0] Q_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] Q_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DISCARD, S_MAC, S_DRAIN, S_STORE, S_OUT} state_t;

  state_t r_state, w_next;

  logic [NOUT_W-1:0]        r_cfg_n_out [N_LAYERS];
  logic [SHIFT_W-1:0]       r_cfg_shift [N_LAYERS];
  logic                     r_cfg_relu  [N_LAYERS];
  logic signed [DATA_W-1:0] r_buf [2][MAX_N];

  logic [IDX_W-1:0]         r_cnt, r_o, r_i, r_oidx;
  logic [NOUT_W-1:0]        r_n_in;
  logic [LAYER_W-1:0]       r_layer;
  logic                     r_src, r_mac_vld;
  logic signed [DATA_W-1:0] r_act;
  logic signed [ACC_W-1:0]  r_acc;

  logic                       w_in_hs, w_out_hs, w_load_full;
  logic                       w_last_i, w_last_o, w_last_layer, w_last_out;
  logic [IDX_W-1:0]           w_wr_idx;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_shifted, w_relu;
  logic                       w_hi, w_lo;
  logic signed [DATA_W-1:0]   w_q;

  assign w_in_hs      = s_axis_tvalid & s_axis_tready;
  assign w_out_hs     = m_axis_tvalid & m_axis_tready;
  assign w_load_full  = (int'(r_cnt) == MAX_N - 1);
  assign w_last_i     = (int'(r_i) == int'(r_n_in) - 1);
  assign w_last_o     = (int'(r_o) == int'(r_cfg_n_out[r_layer]) - 1);
  assign w_last_layer = (int'(r_layer) == N_LAYERS - 1);
  assign w_last_out   = (int'(r_oidx) == int'(r_n_in) - 1);
  assign w_wr_idx     = (r_state == S_IDLE) ? '0 : r_cnt;
  assign w_prod       = r_act * w_rdata;

  assign w_raddr = (r_state == S_MAC)
                 ? ADDR_W'(int'(r_layer) * MAX_N * MAX_N + int'(r_o) * MAX_N + int'(r_i)) : '0;
  assign m_axis_tdata = (r_state == S_OUT) ? r_buf[r_src][r_oidx] : '0;
  assign m_axis_tlast = (r_state == S_OUT) && w_last_out;

  // Requantise the finished accumulator: shift, optional ReLU, then clip to DATA_W.
  always_comb begin
    w_shifted = r_acc >>> r_cfg_shift[r_layer];
    w_relu    = (r_cfg_relu[r_layer] && (w_shifted < 0)) ? '0 : w_shifted;
    w_hi      = (w_relu > ACC_W'(Q_MAX));
    w_lo      = (w_relu < ACC_W'(Q_MIN));
    w_q       = w_relu[DATA_W-1:0];
    if (w_hi) w_q = Q_MAX;
    else if (w_lo) w_q = Q_MIN;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode plus the state-only stream handshake outputs.
  always_comb begin
    w_next        = r_state;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    busy          = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        s_axis_tready = 1'b1;
        busy          = 1'b0;
        if (s_axis_tvalid)
          w_next = s_axis_tlast ? S_MAC : ((MAX_N == 1) ? S_DISCARD : S_LOAD);
      end
      S_LOAD: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          if (s_axis_tlast)     w_next = S_MAC;
          else if (w_load_full) w_next = S_DISCARD;
        end
      end
      S_DISCARD: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) w_next = S_MAC;
      end
      S_MAC:   if (w_last_i) w_next = S_DRAIN;
      S_DRAIN: w_next = S_STORE;
      S_STORE: w_next = (w_last_o && w_last_layer) ? S_OUT : S_MAC;
      S_OUT: begin
        m_axis_tvalid = 1'b1;
        if (m_axis_tready && w_last_out) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Per-layer configuration, writable only while idle; n_out is clamped to 1..MAX_N.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_LAYERS; k++) begin
        r_cfg_n_out[k] <= NOUT_W'(MAX_N);
        r_cfg_shift[k] <= '0;
        r_cfg_relu[k]  <= 1'b1;
      end
    end else if (cfg_wr_en && (r_state == S_IDLE) && (int'(cfg_layer) < N_LAYERS)) begin
      r_cfg_n_out[cfg_layer] <= (cfg_n_out == '0) ? NOUT_W'(1)
                              : ((int'(cfg_n_out) > MAX_N) ? NOUT_W'(MAX_N) : cfg_n_out);
      r_cfg_shift[cfg_layer] <= cfg_shift;
      r_cfg_relu[cfg_layer]  <= cfg_relu;
    end
  end

  // Activation ping-pong storage: input lands in buffer 0, each neuron result goes to the non-source half.
  always_ff @(posedge clk) begin
    if (w_in_hs && ((r_state == S_IDLE) || (r_state == S_LOAD))) r_buf[0][w_wr_idx] <= s_axis_tdata;
    if (r_state == S_STORE) r_buf[~r_src][r_o] <= w_q;
  end

  // Sequencing counters: beat count, input/neuron/layer indices, buffer side and output index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0; r_n_in <= '0; r_layer <= '0; r_o <= '0; r_i <= '0; r_oidx <= '0; r_src <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_in_hs) begin
          r_cnt   <= IDX_W'(1);
          r_layer <= '0;
          r_o     <= '0;
          r_i     <= '0;
          r_oidx  <= '0;
          r_src   <= 1'b0;
          r_n_in  <= NOUT_W'(1);
        end
        S_LOAD: if (w_in_hs) begin
          r_cnt <= r_cnt + IDX_W'(1);
          if (s_axis_tlast)     r_n_in <= NOUT_W'(r_cnt) + NOUT_W'(1);
          else if (w_load_full) r_n_in <= NOUT_W'(MAX_N);
        end
        S_MAC: r_i <= w_last_i ? '0 : r_i + IDX_W'(1);
        S_STORE: begin
          if (w_last_o) begin
            r_o    <= '0;
            r_src  <= ~r_src;
            r_n_in <= r_cfg_n_out[r_layer];
            r_oidx <= '0;
            if (!w_last_layer) r_layer <= r_layer + LAYER_W'(1);
          end else begin
            r_o <= r_o + IDX_W'(1);
          end
        end
        S_OUT: if (w_out_hs) r_oidx <= r_oidx + IDX_W'(1);
        default: ;
      endcase
    end
  end

  // MAC pipeline: activation is registered alongside the weight read so both arrive together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act <= '0; r_mac_vld <= 1'b0; r_acc <= '0;
    end else begin
      r_mac_vld <= (r_state == S_MAC);
      if (r_state == S_MAC) r_act <= r_buf[r_src][r_i];
      if (r_state == S_STORE) r_acc <= '0;
      else if (r_mac_vld)     r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

  // Sticky over-length flag, cleared by the first beat of the next vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_len <= 1'b0;
    else if ((r_state == S_IDLE) && w_in_hs) err_len <= !s_axis_tlast && (MAX_N == 1);
    else if ((r_state == S_LOAD) && w_in_hs && !s_axis_tlast && w_load_full) err_len <= 1'b1;
  end

`ifdef SAT_CNT_EN
  // Count neuron results clipped by saturation (ReLU zeroing is not a clip).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_count <= '0;
    else if ((r_state == S_IDLE) && w_in_hs) sat_count <= '0;
    else if ((r_state == S_STORE) && (w_hi || w_lo) && (sat_count != 16'hFFFF))
      sat_count <= sat_count + 16'd1;
  end
`endif

endmodule
